// File: rtl/fft_bitrev_reorder.sv
// Bit-reversed to natural order reorder buffer for the radix-2 FFT output.
// Two register banks ping-pong: the write side fills one bank at bit-reversed
// addresses while the read side drains the other sequentially.
module fft_bitrev_reorder #(
    parameter int WIDTH  = 16,
    parameter int N_LOG2 = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] in_re,
    input  logic signed [WIDTH-1:0] in_im,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_last,
    output logic signed [WIDTH-1:0] out_re,
    output logic signed [WIDTH-1:0] out_im,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic                    frame_err
);

    localparam int N  = 2 ** N_LOG2;
    localparam int AW = N_LOG2 + 1;

    // Entry layout is {re, im}; address is {bank, index}.
    logic [2*WIDTH-1:0] r_mem [2*N];

    logic              r_wr_bank;
    logic              r_rd_bank;
    logic [N_LOG2-1:0] r_wr_cnt;
    logic [N_LOG2-1:0] r_rd_cnt;
    logic [1:0]        r_full;
    logic              r_frame_err;

    logic [1:0]         w_full_d;
    logic [AW-1:0]      w_wr_addr;
    logic [AW-1:0]      w_rd_addr;
    logic [2*WIDTH-1:0] w_rd_word;
    logic               w_in_fire;
    logic               w_out_fire;
    logic               w_wr_at_end;
    logic               w_rd_at_end;
    logic               w_wr_done;
    logic               w_rd_done;

    function automatic logic [N_LOG2-1:0] f_bitrev(input logic [N_LOG2-1:0] a);
        logic [N_LOG2-1:0] b;
        b = '0;
        for (int i = 0; i < N_LOG2; i++) begin
            b[i] = a[N_LOG2-1-i];
        end
        return b;
    endfunction

    assign in_ready    = !r_full[r_wr_bank];
    assign out_valid   = r_full[r_rd_bank];
    assign w_in_fire   = in_valid && in_ready;
    assign w_out_fire  = out_valid && out_ready;
    assign w_wr_at_end = &r_wr_cnt;
    assign w_rd_at_end = &r_rd_cnt;
    assign w_wr_done   = w_in_fire && w_wr_at_end;
    assign w_rd_done   = w_out_fire && w_rd_at_end;

    assign w_wr_addr = {r_wr_bank, f_bitrev(r_wr_cnt)};
    assign w_rd_addr = {r_rd_bank, r_rd_cnt};
    assign w_rd_word = r_mem[w_rd_addr];

    assign out_re    = w_rd_word[2*WIDTH-1:WIDTH];
    assign out_im    = w_rd_word[WIDTH-1:0];
    assign out_last  = out_valid && w_rd_at_end;
    assign frame_err = r_frame_err;

    // Next full flags; a set and a clear can never hit the same bank in one cycle.
    always_comb begin
        w_full_d = r_full;
        if (w_wr_done) begin
            w_full_d[r_wr_bank] = 1'b1;
        end
        if (w_rd_done) begin
            w_full_d[r_rd_bank] = 1'b0;
        end
    end

    // Pointer, full-flag and sticky error state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_bank   <= 1'b0;
            r_rd_bank   <= 1'b0;
            r_wr_cnt    <= '0;
            r_rd_cnt    <= '0;
            r_full      <= 2'b00;
            r_frame_err <= 1'b0;
        end else begin
            r_full <= w_full_d;
            if (w_in_fire) begin
                r_wr_cnt <= r_wr_cnt + N_LOG2'(1);
                if (in_last != w_wr_at_end) begin
                    r_frame_err <= 1'b1;
                end
            end
            if (w_wr_done) begin
                r_wr_bank <= !r_wr_bank;
            end
            if (w_out_fire) begin
                r_rd_cnt <= r_rd_cnt + N_LOG2'(1);
            end
            if (w_rd_done) begin
                r_rd_bank <= !r_rd_bank;
            end
        end
    end

    // Sample storage; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            r_mem[w_wr_addr] <= {in_re, in_im};
        end
    end

endmodule
